// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle sequencing controller for the MIPS-32 core. A Moore-style FSM
// steps the shared ALU, the unified instruction/data memory and the register
// file through the FETCH, DECODE, EXEC, MEM and WB phases. The opcode is
// captured from the instruction register in DECODE. EXEC, MEM and WB decode
// that captured copy, so the IR may change underneath without effect.
//
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unlisted opcodes in
// TRAP_STATE until reset. Without it, unlisted opcodes retire as NOPs in
// DECODE, and illegal_op is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (also gates all outputs)
//   op_code[5:0] in   IR[31:26]
//   mem_ready    in   memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA
//                out  datapath strobes and mux selects
//   ALUSrcB[1:0] out  00 reg B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   ALUop[2:0]   out  000 add, 001 sub, 010 R-type, 011 and,
//                     100 bne, 101 bgt, 110 bge, 111 ble
//   PCSource[1:0]out  00 ALU result, 01 ALUOut, 10 jump target
//   state[2:0]   out  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4 (trap: TRAP_STATE)
//   instr_done   out  pulse in the final cycle of each instruction
//   illegal_op   out  trap flag (feature build only, else 0)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [2:0] TRAP_STATE = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic [1:0] PCSource,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = TRAP_STATE
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGT  = 6'b000110;
  localparam logic [5:0] OP_BGE  = 6'b000111;
  localparam logic [5:0] OP_BLE  = 6'b001011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_R, OP_ADDI, OP_SUBI, OP_ANDI,
      OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLE,
      OP_LW, OP_SW, OP_J: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t     state_r;
  state_t     next_s;
  logic [5:0] op_r;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       i_or_d_s;
  logic       ir_write_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       mem_to_reg_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [2:0] alu_op_s;
  logic [1:0] pc_source_s;
  logic       instr_done_s;
  logic       illegal_s;

  // State register and opcode capture (opcode sampled on leaving DECODE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      op_r    <= 6'b000000;
    end else begin
      state_r <= next_s;
      if (state_r == S_DECODE) begin
        op_r <= op_code;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state and Moore output decode; mem_ready only gates FETCH/MEM.
  always_comb begin
    next_s          = state_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    ir_write_s      = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 3'b000;
    pc_source_s     = 2'b00;
    instr_done_s    = 1'b0;
    illegal_s       = 1'b0;

    case (state_r)
      S_FETCH: begin
        // PC + 4 is computed by the ALU while the instruction is read.
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
        if (mem_ready) begin
          next_s = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut for use in EXEC.
        alu_src_b_s = 2'b11;
        if (op_code == OP_J) begin
          pc_write_s   = 1'b1;
          pc_source_s  = 2'b10;
          instr_done_s = 1'b1;
          next_s       = S_FETCH;
        end else if (is_legal(op_code)) begin
          next_s = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          next_s = S_TRAP;
`else
          instr_done_s = 1'b1;
          next_s       = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        alu_src_a_s = 1'b1;
        case (op_r)
          OP_R: begin
            alu_src_b_s = 2'b00;
            alu_op_s    = 3'b010;
            next_s      = S_WB;
          end
          OP_ADDI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b000;
            next_s      = S_WB;
          end
          OP_SUBI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b001;
            next_s      = S_WB;
          end
          OP_ANDI: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b011;
            next_s      = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b_s = 2'b10;
            alu_op_s    = 3'b000;
            next_s      = S_MEM;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLE: begin
            alu_src_b_s     = 2'b00;
            pc_write_cond_s = 1'b1;
            pc_source_s     = 2'b01;
            instr_done_s    = 1'b1;
            next_s          = S_FETCH;
            case (op_r)
              OP_BEQ:  alu_op_s = 3'b001;
              OP_BNE:  alu_op_s = 3'b100;
              OP_BGT:  alu_op_s = 3'b101;
              OP_BGE:  alu_op_s = 3'b110;
              OP_BLE:  alu_op_s = 3'b111;
              default: alu_op_s = 3'b000;
            endcase
          end
          default: begin
            // Not reachable from DECODE; recover quietly.
            alu_src_a_s = 1'b0;
            next_s      = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        // Strobes depend only on state and op_r, so they stay stable
        // across wait cycles.
        i_or_d_s = 1'b1;
        if (op_r == OP_LW) begin
          mem_read_s = 1'b1;
          if (mem_ready) begin
            next_s = S_WB;
          end else begin
            next_s = S_MEM;
          end
        end else if (op_r == OP_SW) begin
          mem_write_s = 1'b1;
          if (mem_ready) begin
            instr_done_s = 1'b1;
            next_s       = S_FETCH;
          end else begin
            next_s = S_MEM;
          end
        end else begin
          i_or_d_s = 1'b0;
          next_s   = S_FETCH;
        end
      end

      S_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        reg_dst_s    = (op_r == OP_R);
        mem_to_reg_s = (op_r == OP_LW);
        next_s       = S_FETCH;
      end

      S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_s = 1'b1;
        next_s    = S_TRAP;
`else
        next_s = S_FETCH;
`endif
      end

      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Holding rst_n low forces every output to 0 without waiting for a clock.
  assign PCWrite     = rst_n & pc_write_s;
  assign PCWriteCond = rst_n & pc_write_cond_s;
  assign IorD        = rst_n & i_or_d_s;
  assign IRWrite     = rst_n & ir_write_s;
  assign MemRead     = rst_n & mem_read_s;
  assign MemWrite    = rst_n & mem_write_s;
  assign MemtoReg    = rst_n & mem_to_reg_s;
  assign RegDst      = rst_n & reg_dst_s;
  assign RegWrite    = rst_n & reg_write_s;
  assign ALUSrcA     = rst_n & alu_src_a_s;
  assign ALUSrcB     = {2{rst_n}} & alu_src_b_s;
  assign ALUop       = {3{rst_n}} & alu_op_s;
  assign PCSource    = {2{rst_n}} & pc_source_s;
  assign instr_done  = rst_n & instr_done_s;
  assign state       = state_r;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = rst_n & illegal_s;
`else
  assign illegal_op = 1'b0;
  // illegal_s is only meaningful in the trap build.
  logic unused_s;
  assign unused_s = illegal_s;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Inputs change in the low clock phase
// and outputs are checked 1 time unit later, well away from the rising edge.
// Each expected output vector is written out by hand per cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUop;
  logic [1:0] PCSource;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  logic [18:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
                 PCSource, instr_done, illegal_op};

  // Pack an expected output vector in the same order as outs.
  function automatic logic [18:0] ex(
    input logic pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] pcs,
    input logic done, ill);
    return {pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, asa, asb, aop, pcs, done, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle (state + outputs), then advance to the next low phase.
  task automatic step(input string tag, input logic [2:0] st_e, input logic [18:0] o_e);
    #1;
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st_e});
    chk({tag, ".outs"},  {13'd0, outs},  {13'd0, o_e});
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [18:0] f_rdy, f_wait, dec, zero;

  initial begin
    //             pcw  pcwc iord irw  mr   mw   m2r  rd   rw   asa  asb    aop     pcs    done ill
    f_rdy  = ex(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0,1'b0);
    f_wait = ex(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0,1'b0);
    dec    = ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b0,1'b0);
    zero   = 19'd0;

    rst_n = 1'b0; op_code = 6'b000000; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("reset.state", {29'd0, state}, 32'd0);
    chk("reset.outs", {13'd0, outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI, zero wait; IR changes during EXEC must not matter.
    mem_ready = 1'b1; op_code = 6'b001000;
    step("addi.fetch", 3'd0, f_rdy);
    step("addi.decode", 3'd1, dec);
    op_code = 6'b000000;
    step("addi.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0));
    step("addi.wb", 3'd4, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0));

    // LW with two wait cycles in MEM.
    op_code = 6'b100011;
    step("lw.fetch", 3'd0, f_rdy);
    step("lw.decode", 3'd1, dec);
    step("lw.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0));
    mem_ready = 1'b0;
    step("lw.mem0", 3'd3, ex(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0));
    step("lw.mem1", 3'd3, ex(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0));
    mem_ready = 1'b1;
    step("lw.mem2", 3'd3, ex(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0));
    step("lw.wb", 3'd4, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0));

    // BLE then J.
    op_code = 6'b001011;
    step("ble.fetch", 3'd0, f_rdy);
    step("ble.decode", 3'd1, dec);
    step("ble.exec", 3'd2, ex(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b111,2'b01,1'b1,1'b0));
    op_code = 6'b000010;
    step("j.fetch", 3'd0, f_rdy);
    step("j.decode", 3'd1, ex(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b10,1'b1,1'b0));

    // SW with three FETCH wait cycles.
    op_code = 6'b101011; mem_ready = 1'b0;
    step("sw.fwait0", 3'd0, f_wait);
    step("sw.fwait1", 3'd0, f_wait);
    step("sw.fwait2", 3'd0, f_wait);
    mem_ready = 1'b1;
    step("sw.fetch", 3'd0, f_rdy);
    step("sw.decode", 3'd1, dec);
    step("sw.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0));
    step("sw.mem", 3'd3, ex(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0));

    // R-type.
    op_code = 6'b000000;
    step("r.fetch", 3'd0, f_rdy);
    step("r.decode", 3'd1, dec);
    step("r.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,1'b0,1'b0));
    step("r.wb", 3'd4, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0));

    // ANDI and BNE: EXEC encodings only.
    op_code = 6'b001100;
    step("andi.fetch", 3'd0, f_rdy);
    step("andi.decode", 3'd1, dec);
    step("andi.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,2'b00,1'b0,1'b0));
    step("andi.wb", 3'd4, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0));
    op_code = 6'b000101;
    step("bne.fetch", 3'd0, f_rdy);
    step("bne.decode", 3'd1, dec);
    step("bne.exec", 3'd2, ex(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b01,1'b1,1'b0));

    // Reset asserted in the middle of a stalled LW MEM phase.
    op_code = 6'b100011;
    step("rlw.fetch", 3'd0, f_rdy);
    step("rlw.decode", 3'd1, dec);
    mem_ready = 1'b0;
    step("rlw.exec", 3'd2, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0));
    #1;
    chk("rlw.mem.state", {29'd0, state}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rlw.rst.state", {29'd0, state}, 32'd0);
    chk("rlw.rst.outs", {13'd0, outs}, {13'd0, zero});
    @(negedge clk);
    rst_n = 1'b1;
    step("rlw.refetch", 3'd0, f_wait);

    // Unlisted opcode 111111.
    op_code = 6'b111111; mem_ready = 1'b1;
    step("ill.fetch", 3'd0, f_rdy);
`ifdef MC_ILLEGAL_TRAP_EN
    step("ill.decode", 3'd1, dec);
    for (int i = 0; i < 12; i++) begin
      step("ill.trap", 3'b111, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b1));
    end
`else
    step("ill.decode", 3'd1, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b1,1'b0));
    op_code = 6'b001000;
    step("ill.next_fetch", 3'd0, f_rdy);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS-32 core. It replaces single-cycle decode with a Moore-style FSM that steps one shared ALU, one unified instruction/data memory and the register file through the FETCH, DECODE, EXEC, MEM and WB phases. It decodes the same opcode set and ALUop encoding as the single-cycle control path. It stalls on a memory ready handshake and sits between the instruction register and the datapath muxes and enables.

## Interface
Parameters:
- `TRAP_STATE`, 3'b111: encoding of the trap state (used only with the macro).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op_code`  in  6  opcode from the instruction register, `IR[31:26]`
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `IRWrite`, `MemRead`, `MemWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath strobes and mux selects
- `ALUSrcB`  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `ALUop`  out  3  same encoding as single-cycle control: 000 add, 001 sub, 010 R-type, 011 and, 100 bne, 101 bgt, 110 bge, 111 ble
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  3  current state: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal_op`  out  1  trap flag (macro only; otherwise tied 0)

## Operation
- **Supported opcodes:** R 000000, ADDI 001000, SUBI 001001, ANDI 001100, BEQ 000100, BNE 000101, BGT 000110, BGE 000111, BLE 001011, LW 100011, SW 101011, J 000010.
- **Opcode latch:** `op_code` is latched into an internal register in DECODE. EXEC, MEM and WB use the latched copy.
- **Output defaults:** every output not listed for a state is 0.
- **FETCH:**
  - Drives `MemRead=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUop=000`, `PCSource=00`.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - On `mem_ready` go to DECODE; otherwise hold.
- **DECODE:**
  - Drives `ALUSrcA=0`, `ALUSrcB=11`, `ALUop=000` to precompute the branch target.
  - J: `PCWrite=1`, `PCSource=10`, `instr_done=1`, next FETCH.
  - Any other legal opcode: next EXEC.
- **EXEC:**
  - R-type: `ALUSrcA=1`, `ALUSrcB=00`, `ALUop=010`, next WB.
  - ADDI/SUBI/ANDI: `ALUSrcA=1`, `ALUSrcB=10`, `ALUop` = 000/001/011, next WB.
  - LW/SW: `ALUSrcA=1`, `ALUSrcB=10`, `ALUop=000`, next MEM.
  - Branches: `ALUSrcA=1`, `ALUSrcB=00`, `ALUop` = 001 (BEQ), 100, 101, 110, 111; `PCWriteCond=1`, `PCSource=01`, `instr_done=1`, next FETCH.
- **MEM:**
  - Drives `IorD=1`, plus `MemRead=1` (LW) or `MemWrite=1` (SW). The strobe is held stable until `mem_ready`.
  - LW with `mem_ready` goes to WB.
  - SW with `mem_ready` asserts `instr_done` and goes to FETCH.
- **WB:**
  - Drives `RegWrite=1`, `instr_done=1`, next FETCH.
  - `RegDst=1` for R-type; `MemtoReg=1` for LW.

## Timing
- **Reset:** while `rst_n` is low, `state` is FETCH and every output, including all strobes, is forced to 0 asynchronously.
- **Start-up:** the first active FETCH cycle is the first clock after `rst_n` rises.
- **Minimum latency with zero wait, in cycles:**
  - J: 2
  - Branch: 3
  - R-type, immediate and SW: 4
  - LW: 5
- **Wait states:** each cycle `mem_ready` is low in FETCH or MEM adds one cycle. Outputs are stable across wait cycles.
- **Early ready:** `mem_ready` high outside FETCH/MEM is ignored.
- **Reset mid-instruction:** the instruction is aborted with no further strobes. Execution restarts at FETCH with no partial writeback.
- **Output timing:** outputs are a combinational decode of `state` and the latched opcode. The exceptions are `IRWrite`/`PCWrite` in FETCH, which also depend on `mem_ready`.

## Configuration
- **`MC_ILLEGAL_TRAP_EN` defined:**
  - An unlisted opcode in DECODE moves the FSM to `TRAP_STATE`.
  - `illegal_op` is 1 and all strobes are 0.
  - The FSM stays in the trap until reset.
- **`MC_ILLEGAL_TRAP_EN` undefined:**
  - An unlisted opcode executes as a NOP: DECODE asserts `instr_done`, next FETCH.
  - `illegal_op` is constant 0.

## Test plan
- **Reset mid-LW:** `rst_n` low during MEM -> all strobes 0 immediately; `state`=0; after release, FETCH asserts `MemRead=1`.
- **ADDI, `mem_ready` always 1:** states 0,1,2,4; EXEC `ALUSrcB=10`, `ALUop=000`; WB `RegWrite=1`, `RegDst=0`; `instr_done` in cycle 4.
- **LW with 2 wait cycles in MEM:** states 0,1,2,3,3,3,4; `MemRead`=`IorD`=1 held through all MEM cycles; WB `MemtoReg=1`; total 7 cycles.
- **BLE then J:**
  - BLE: EXEC `ALUop=111`, `PCWriteCond=1`, `PCSource=01`, 3 cycles.
  - J: DECODE `PCWrite=1`, `PCSource=10`, 2 cycles.
- **SW with FETCH stall:** `mem_ready` low for 3 cycles in FETCH -> `IRWrite`=0 until ready; MEM `MemWrite=1`; never `RegWrite`.
- **Opcode 111111:** with macro -> `illegal_op=1`, FSM stays in `TRAP_STATE` for 10+ cycles; without macro -> `instr_done` in DECODE, then FETCH.
